// File: rtl/instr_mem_loader.sv
// Byte-serial instruction-memory loader: assembles MSB-first bytes into
// 32-bit words, writes them at consecutive word addresses, and stops on
// a halt word or when the memory is full.
module instr_mem_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int unsigned WCW = $clog2(DEPTH) + 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    FINISH
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [23:0]    word_q, word_d;
  logic           wr_en_q, wr_en_d;
  logic [31:0]    wr_addr_q, wr_addr_d;
  logic [31:0]    wr_data_q, wr_data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           overflow_q, overflow_d;

  // Next-state and next-output logic; write outputs are staged one edge
  // early so that they are registered and valid during the WRITE cycle.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    word_d     = word_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = '0;
    wr_data_d  = '0;
    busy_d     = busy_q;
    done_d     = done_q;
    overflow_d = overflow_q;

    if (start) begin
      // start from any state (re)opens a session; any partial word and
      // any write not yet staged is discarded.
      state_d    = RECV;
      byte_cnt_d = '0;
      word_cnt_d = '0;
      word_d     = '0;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        RECV: begin
          if (rx_valid) begin
            word_d = {word_q[15:0], rx_data};
            if (byte_cnt_q == 2'd3) begin
              state_d    = WRITE;
              byte_cnt_d = '0;
              wr_en_d    = 1'b1;
              wr_addr_d  = 32'({word_cnt_q, 2'b00});
              wr_data_d  = {word_q, rx_data};
            end else begin
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end
        end
        WRITE: begin
          if (wr_data_q == HALT_WORD) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (word_cnt_q == LAST_WORD) begin
            state_d    = FINISH;
            busy_d     = 1'b0;
            overflow_d = 1'b1;
          end else begin
            state_d    = RECV;
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      word_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      word_q     <= word_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a write scoreboard.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        overflow;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic        mon_on      = 1'b0;
  logic [63:0] exp_q[$];

  instr_mem_loader #(.DEPTH(256), .HALT_WORD(32'hFFFFFFFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: every strobe must match the oldest expected write;
  // outside a strobe the address and data buses must be zero.
  always @(negedge clk) begin
    if (mon_on) begin
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr_en", {31'd0, wr_en}, 32'd0);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e[63:32]);
          check("wr_data", wr_data, e[31:0]);
        end
      end else begin
        check("idle_addr", wr_addr, 32'd0);
        check("idle_data", wr_data, 32'd0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  // Four back-to-back bytes, then one idle cycle covering the WRITE state.
  task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit expect_wr);
    if (expect_wr) exp_q.push_back({addr, w});
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    tick();
  endtask

  task automatic check_status(input string tag, input logic b, input logic d, input logic o);
    @(negedge clk);
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, o});
    check({tag, "_pending"}, exp_q.size(), 32'd0);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    tick();
    tick();
    mon_on = 1'b1;
    @(negedge clk);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();

    // Two-word program ending in the halt word.
    pulse_start();
    @(negedge clk);
    check("t1_busy_after_start", {31'd0, busy}, 32'd1);
    #1;
    send_word(32'h20080005, 32'h0, 1'b1);
    send_word(32'hFFFFFFFF, 32'h4, 1'b1);
    tick();
    check_status("t1", 1'b0, 1'b1, 1'b0);

    // Fill the whole memory without a halt word; start from FINISH.
    pulse_start();
    @(negedge clk);
    check("t2_done_cleared", {31'd0, done}, 32'd0);
    #1;
    for (int i = 0; i < 256; i++)
      send_word(32'h1000_0000 + i, i * 4, 1'b1);
    // A further word must not be written at 0x400.
    send_word(32'h12345678, 32'h400, 1'b0);
    check_status("t2", 1'b0, 1'b0, 1'b1);

    // Partial word discarded by a restart.
    pulse_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    pulse_start();
    send_word(32'h00000000, 32'h0, 1'b1);
    send_word(32'hFFFFFFFF, 32'h4, 1'b1);
    tick();
    check_status("t3", 1'b0, 1'b1, 1'b0);

    // Reset on the cycle the 4th byte is sampled.
    pulse_start();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    rx_valid = 1'b1;
    rx_data  = 8'h44;
    reset    = 1'b1;
    tick();
    rx_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    check("t4_wr_en", {31'd0, wr_en}, 32'd0);
    check("t4_addr", wr_addr, 32'd0);
    check("t4_data", wr_data, 32'd0);
    check_status("t4", 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // Bytes in IDLE without start are ignored.
    send_word(32'h01020304, 32'h0, 1'b0);
    send_word(32'hFFFFFFFF, 32'h4, 1'b0);
    check_status("t5_idle", 1'b0, 1'b0, 1'b0);
    // Reach FINISH, then bytes must not disturb it.
    pulse_start();
    send_word(32'hFFFFFFFF, 32'h0, 1'b1);
    tick();
    check_status("t5_fin", 1'b0, 1'b1, 1'b0);
    send_word(32'hDEADBEEF, 32'h0, 1'b0);
    send_word(32'hFFFFFFFF, 32'h4, 1'b0);
    check_status("t5_after", 1'b0, 1'b1, 1'b0);

    // Halt word as the last possible word: done wins over overflow.
    pulse_start();
    for (int i = 0; i < 255; i++)
      send_word(32'h2000_0000 + i, i * 4, 1'b1);
    send_word(32'hFFFFFFFF, 32'h3FC, 1'b1);
    tick();
    check_status("t6", 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
